// File: rtl/fir_pkg.sv
// Shared types for the FIR coefficient loader: default sizing, FSM state encoding
// and the coefficient-bank layout (tap k in element k, i.e. bits [DW*k +: DW]).
package fir_pkg;

  localparam int NTAPS_DEF = 16;
  localparam int DW_DEF    = 16;

`ifdef COEFF_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } fir_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd3
  } fir_state_t;
`endif

  typedef logic [DW_DEF-1:0]           coeff_t;
  typedef coeff_t [NTAPS_DEF-1:0]      coeff_bank_t;

  // Index width that stays legal for a single-tap bank.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Control, configuration-stream and coefficient-output signals of the loader.
// master drives start/abort/cfg words; slave is the loader itself.
interface fir_coeff_loader_if #(
  parameter int NTAPS = fir_pkg::NTAPS_DEF,
  parameter int DW    = fir_pkg::DW_DEF
);

  logic                  start;
  logic                  abort;
  logic                  cfg_valid;
  logic [DW-1:0]         cfg_data;
  logic                  cfg_ready;
  logic [NTAPS*DW-1:0]   h_flat;
  logic                  coeff_update;
  logic                  busy;
  logic                  chk_err;

  modport master (
    output start, abort, cfg_valid, cfg_data,
    input  cfg_ready, h_flat, coeff_update, busy, chk_err
  );

  modport slave (
    input  start, abort, cfg_valid, cfg_data,
    output cfg_ready, h_flat, coeff_update, busy, chk_err
  );

endinterface

// File: rtl/fir_coeff_bank.sv
// Shadow + active coefficient registers; shadow written one word per enable.
// Latency: shadow write and commit both take effect on the next rising edge.
// Backpressure: none, every write/commit request is taken unconditionally.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int  NTAPS = NTAPS_DEF,
  parameter int  DW    = DW_DEF,
  localparam int IW    = idx_width(NTAPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_idx,
  input  logic [DW-1:0]       wr_data,
  input  logic                commit,
  output logic [NTAPS*DW-1:0] h_flat
);

  logic [NTAPS-1:0][DW-1:0] shadow_q;
  logic [NTAPS-1:0][DW-1:0] active_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (wr_en) begin
        shadow_q[wr_idx] <= wr_data;
      end
      if (commit) begin
        active_q <= shadow_q;
      end
    end
  end

  assign h_flat = active_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// Loads NTAPS coefficients into a shadow bank, then commits them atomically to h_flat.
// Latency: h_flat/coeff_update change one edge after the last accepted word (or checksum).
// Backpressure: cfg_ready only in LOAD/CHECK; optional checksum word with COEFF_CHECKSUM_EN.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  fir_coeff_loader_if.slave bus
);

  localparam int            IW       = idx_width(NTAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

  fir_state_t    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          load_begin;
  logic          word_acc;
  logic          commit;
  logic          cfg_rdy;
  logic          upd_q;

`ifdef COEFF_CHECKSUM_EN
  logic [DW-1:0] sum_q;
  logic          chk_fail;
  logic          chk_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      upd_q   <= commit;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    load_begin = 1'b0;
    word_acc   = 1'b0;
    commit     = 1'b0;
    cfg_rdy    = 1'b0;
`ifdef COEFF_CHECKSUM_EN
    chk_fail   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d    = ST_LOAD;
          load_begin = 1'b1;
        end
      end
      ST_LOAD: begin
        cfg_rdy = 1'b1;
        // abort beats start; a restart swallows any word offered that cycle
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          load_begin = 1'b1;
        end else if (bus.cfg_valid) begin
          word_acc = 1'b1;
          idx_d    = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
`ifdef COEFF_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_COMMIT;
`endif
          end
        end
      end
`ifdef COEFF_CHECKSUM_EN
      ST_CHECK: begin
        cfg_rdy = 1'b1;
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.cfg_valid) begin
          if (bus.cfg_data == sum_q) begin
            state_d = ST_COMMIT;
          end else begin
            state_d  = ST_IDLE;
            chk_fail = 1'b1;
          end
        end
      end
`endif
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_begin) begin
      idx_d = '0;
    end
  end

`ifdef COEFF_CHECKSUM_EN
  // Running modulo-2^DW sum of the words accepted since the last (re)start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= chk_fail;
      if (load_begin) begin
        sum_q <= '0;
      end else if (word_acc) begin
        sum_q <= sum_q + bus.cfg_data;
      end
    end
  end

  assign bus.chk_err = chk_err_q;
`else
  assign bus.chk_err = 1'b0;
`endif

  fir_coeff_bank #(
    .NTAPS (NTAPS),
    .DW    (DW)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (word_acc),
    .wr_idx  (idx_q),
    .wr_data (bus.cfg_data),
    .commit  (commit),
    .h_flat  (bus.h_flat)
  );

  assign bus.cfg_ready    = cfg_rdy;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.coeff_update = upd_q;

endmodule
